// File: rtl/sine_analyzer_if.sv
// Sample stream in, period/peak measurement results out.
interface sine_analyzer_if #(
   parameter int DW = 16
);
   logic signed [DW-1:0] sample_in;
   logic                 sample_valid;
   logic [31:0]          period;
   logic signed [DW-1:0] peak_pos;
   logic signed [DW-1:0] peak_neg;
   logic                 meas_valid;
   logic                 locked;
   logic                 timeout;

   modport master (
      output sample_in, sample_valid,
      input  period, peak_pos, peak_neg,
      input  meas_valid, locked, timeout
   );

   modport slave (
      input  sample_in, sample_valid,
      output period, peak_pos, peak_neg,
      output meas_valid, locked, timeout
   );
endinterface

// File: rtl/sine_analyzer.sv
// Period and peak meter on rising zero crossings with hysteresis.
// Optional 4-period averaging of the period output: SINE_ANALYZER_AVG_EN.
module sine_analyzer #(
   parameter int DW      = 16,
   parameter int HYST    = 64,
   parameter int TIMEOUT = 10000000
)(
   input  logic          clk,
   input  logic          reset,
   sine_analyzer_if.slave bus
);

   typedef enum logic [1:0] {S_UNK, S_LOW, S_HIGH} state_t;

   localparam logic signed [DW-1:0] HYS_P  = DW'(HYST);
   localparam logic signed [DW-1:0] HYS_N  = -HYS_P;
   localparam logic [31:0]          TO_CNT = 32'(TIMEOUT);

   state_t r_state;
   state_t w_state_nxt;

   logic signed [DW-1:0] w_s;
   logic                 w_hi;
   logic                 w_lo;
   logic                 w_event;
   logic                 w_to;
   logic                 w_pub;
   logic                 w_upd;
   logic [31:0]          w_per_nxt;

   logic [31:0]          r_cnt;
   logic                 r_first;
   logic signed [DW-1:0] r_max;
   logic signed [DW-1:0] r_min;
   logic [31:0]          r_period;
   logic signed [DW-1:0] r_pos;
   logic signed [DW-1:0] r_neg;
   logic                 r_mv;
   logic                 r_locked;
   logic                 r_timeout;

   assign w_s  = bus.sample_in;
   assign w_hi = bus.sample_valid && (w_s >= HYS_P);
   assign w_lo = bus.sample_valid && (w_s <= HYS_N);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_UNK;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_to) begin
         w_state_nxt = S_UNK;
      end else begin
         unique case (r_state)
            S_UNK: begin
               if (w_hi)      w_state_nxt = S_HIGH;
               else if (w_lo) w_state_nxt = S_LOW;
            end
            S_LOW:  if (w_hi) w_state_nxt = S_HIGH;
            S_HIGH: if (w_lo) w_state_nxt = S_LOW;
            default: w_state_nxt = S_UNK;
         endcase
      end
   end

   // An event on the count-expiry cycle suppresses the timeout.
   always_comb begin
      w_event = w_hi && (r_state == S_LOW);
      w_to    = !w_event && (r_cnt == TO_CNT);
      w_pub   = w_event && r_first;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_first <= 1'b0;
      end else begin
         if (w_event)        r_cnt <= 32'd1;
         else if (w_to)      r_cnt <= '0;
         else if (~&r_cnt)   r_cnt <= r_cnt + 32'd1;
         if (w_to)           r_first <= 1'b0;
         else if (w_event)   r_first <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_max <= '0;
         r_min <= '0;
      end else if (w_event) begin
         r_max <= w_s;
         r_min <= w_s;
      end else if (bus.sample_valid) begin
         if (w_s > r_max) r_max <= w_s;
         if (w_s < r_min) r_min <= w_s;
      end
   end

`ifdef SINE_ANALYZER_AVG_EN
   logic [31:0] r_hist [3];
   logic [2:0]  r_nmeas;
   logic [33:0] w_sum;

   assign w_sum = {2'b00, r_cnt} + {2'b00, r_hist[0]}
                + {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
   assign w_upd     = w_pub && (r_nmeas >= 3'd3);
   assign w_per_nxt = w_sum[33:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) r_hist[i] <= '0;
         r_nmeas <= '0;
      end else if (w_to) begin
         for (int i = 0; i < 3; i++) r_hist[i] <= '0;
         r_nmeas <= '0;
      end else if (w_pub) begin
         r_hist[0] <= r_cnt;
         r_hist[1] <= r_hist[0];
         r_hist[2] <= r_hist[1];
         if (r_nmeas < 3'd4) r_nmeas <= r_nmeas + 3'd1;
      end
   end
`else
   assign w_upd     = w_pub;
   assign w_per_nxt = r_cnt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period  <= '0;
         r_pos     <= '0;
         r_neg     <= '0;
         r_mv      <= 1'b0;
         r_locked  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_mv      <= w_upd;
         r_timeout <= w_to;
         if (w_to)       r_locked <= 1'b0;
         else if (w_upd) r_locked <= 1'b1;
         if (w_upd) begin
            r_period <= w_per_nxt;
            r_pos    <= r_max;
            r_neg    <= r_min;
         end
      end
   end

   assign bus.period     = r_period;
   assign bus.peak_pos   = r_pos;
   assign bus.peak_neg   = r_neg;
   assign bus.meas_valid = r_mv;
   assign bus.locked     = r_locked;
   assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_sine_analyzer.sv
// Directed bench for sine_analyzer: table of sample segments plus
// hand sequences for asynchronous reset recovery.
module tb_sine_analyzer;

   localparam int DW = 16;
   localparam int TO = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   sine_analyzer_if #(.DW(DW)) bus ();

   sine_analyzer #(.DW(DW), .HYST(64), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      bit v;
      int n;
      bit c;
      bit mv;
      int per;
      int pos;
      int neg;
      bit lk;
      bit to;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input bit mv, input int per,
                            input int pos, input int neg, input bit lk,
                            input bit to);
      check({tag, "_mv"},  int'(bus.meas_valid), int'(mv));
      check({tag, "_per"}, int'(bus.period), per);
      check({tag, "_pos"}, int'($signed(bus.peak_pos)), pos);
      check({tag, "_neg"}, int'($signed(bus.peak_neg)), neg);
      check({tag, "_lk"},  int'(bus.locked), int'(lk));
      check({tag, "_to"},  int'(bus.timeout), int'(to));
   endtask

   task automatic apply(input int s, input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.sample_in    = DW'(s);
         bus.sample_valid = v;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;

      tbl.push_back('{-100, 1,   5, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 200, 1,   1, 1, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 500, 1,  10, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{  30, 1,   5, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{-700, 1,   4, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{9000, 0,   6, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 100, 1,   1, 1, 1,  26, 500, -700, 1, 0});
      tbl.push_back('{ 100, 1,   1, 1, 0,  26, 500, -700, 1, 0});
      tbl.push_back('{  63, 1,   3, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ -64, 1,   2, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{  64, 1,   1, 1, 1,   7, 100,  -64, 1, 0});
      tbl.push_back('{-200, 1,   2, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{  40, 1,   3, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ -40, 1,   3, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{  63, 1,   2, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 300, 1,   1, 1, 1,  11,  64, -200, 1, 0});
      tbl.push_back('{ 100, 1, 299, 1, 0,  11,  64, -200, 1, 0});
      tbl.push_back('{ 100, 1,   1, 1, 0,  11,  64, -200, 0, 1});
      tbl.push_back('{ 100, 1,   1, 1, 0,  11,  64, -200, 0, 0});
      tbl.push_back('{-100, 1,   3, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 100, 1,   1, 1, 0,  11,  64, -200, 0, 0});
      tbl.push_back('{-100, 1,   4, 0, 0,   0,   0,    0, 0, 0});
      tbl.push_back('{ 100, 1,   1, 1, 1,   5, 100, -100, 1, 0});
      tbl.push_back('{-100, 1, 299, 1, 0,   5, 100, -100, 1, 0});
      tbl.push_back('{ 100, 1,   1, 1, 1, 300, 100, -100, 1, 0});
      tbl.push_back('{ 100, 1,   1, 1, 0, 300, 100, -100, 1, 0});

      repeat (3) @(posedge clk);
      #1;
      check_all("rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].s, tbl[i].v, tbl[i].n);
         if (tbl[i].c)
            check_all($sformatf("v%0d", i), tbl[i].mv, tbl[i].per,
                      tbl[i].pos, tbl[i].neg, tbl[i].lk, tbl[i].to);
      end

      // Asynchronous reset while locked, then two fresh events.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all("arst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply(-100, 1, 3);
      apply( 100, 1, 1);
      check_all("rel_ev1", 0, 0, 0, 0, 0, 0);
      apply(-100, 1, 3);
      apply( 100, 1, 1);
      check_all("rel_ev2", 1, 4, 100, -100, 1, 0);
      apply( 100, 1, 1);
      check_all("rel_post", 0, 4, 100, -100, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
